// File: rtl/jtag_dr_bank.sv
// rtl/jtag_dr_bank.sv - JTAG DR bank: shared capture/shift register, per-channel shadow registers (optional length check: JTAG_DR_LEN_CHECK_EN)
module jtag_dr_bank #(
  parameter int                   DR_WIDTH = 8,
  parameter int                   NUM_CH   = 4,
  parameter logic [DR_WIDTH-1:0]  RST_VAL  = '0,
  localparam int                  SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         tck,
  input  logic                         trst,
  input  logic [SEL_W-1:0]             ch_sel,
  input  logic                         dr_capture,
  input  logic                         dr_shift,
  input  logic                         dr_update,
  input  logic                         tdi,
  input  logic [NUM_CH*DR_WIDTH-1:0]   cap_data,
  output logic                         tdo,
  output logic [NUM_CH*DR_WIDTH-1:0]   upd_data,
  output logic [NUM_CH-1:0]            upd_stb,
  output logic                         len_err
);

  localparam logic [SEL_W:0] NUM_CH_V = (SEL_W + 1)'(NUM_CH);

  logic [DR_WIDTH-1:0] sr;
  logic [SEL_W-1:0]    sel_q;
  logic [DR_WIDTH-1:0] shadow  [NUM_CH];
  logic [DR_WIDTH-1:0] cap_arr [NUM_CH];
  logic                in_range;
  logic [SEL_W-1:0]    sel_cap;
  logic                do_update;
  logic                len_ok;

  // Unpack the flat capture bus and repack the shadow registers onto upd_data
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign cap_arr[k]                          = cap_data[k*DR_WIDTH +: DR_WIDTH];
    assign upd_data[k*DR_WIDTH +: DR_WIDTH]    = shadow[k];
  end

  // Out-of-range selects fall back to channel 0
  assign in_range  = ({1'b0, ch_sel} < NUM_CH_V);
  assign sel_cap   = in_range ? ch_sel : '0;
  assign do_update = dr_update && !dr_capture && !dr_shift;
  assign tdo       = sr[0];

`ifdef JTAG_DR_LEN_CHECK_EN
  localparam int                CNT_W    = $clog2(DR_WIDTH + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DR_WIDTH);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(DR_WIDTH + 1);

  logic [CNT_W-1:0] cnt;
  logic             err_q;

  assign len_ok  = (cnt == CNT_FULL);
  assign len_err = err_q;

  // Shift-length counter and sticky error: cleared by capture, set by a mis-sized update or bad select
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else if (dr_capture) begin
      cnt   <= '0;
      err_q <= !in_range;
    end else if (dr_shift) begin
      if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
    end else if (dr_update && !len_ok) begin
      err_q <= 1'b1;
    end
  end
`else
  assign len_ok  = 1'b1;
  assign len_err = 1'b0;
`endif

  // Capture/shift register, held select, shadow commit and one-cycle update strobe
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      sr      <= '0;
      sel_q   <= '0;
      upd_stb <= '0;
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= RST_VAL;
    end else begin
      upd_stb <= '0;
      if (dr_capture) begin
        sel_q <= sel_cap;
        sr    <= cap_arr[sel_cap];
      end else if (dr_shift) begin
        sr <= {tdi, sr[DR_WIDTH-1:1]};
      end else if (do_update && len_ok) begin
        shadow[sel_q]  <= sr;
        upd_stb[sel_q] <= 1'b1;
      end
    end
  end

endmodule
